// File: rtl/tlb_pkg.sv
// Shared types and width helpers for tlb_set_assoc.
// Sized for the default 64-bit address / 12-bit page / 12-bit PCID build.
package tlb_pkg;

    localparam int unsigned TLB_ADDR_W = 64;
    localparam int unsigned TLB_PAGE_W = 12;
    localparam int unsigned TLB_PCID_W = 12;
    localparam int unsigned TLB_VPN_W  = TLB_ADDR_W - TLB_PAGE_W;

    // Tag field is wide enough for any SETS>=2 tag; narrower tags are stored zero-extended.
    typedef struct packed {
        logic                  valid;
        logic [TLB_VPN_W-1:0]  tag;
        logic [TLB_PCID_W-1:0] pcid;
        logic [TLB_VPN_W-1:0]  ppn;
    } tlb_entry_t;

    typedef enum logic {IDLE, FLUSH} tlb_state_e;

    function automatic int unsigned idx_width(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned page_w,
                                              input int unsigned sets);
        return addr_w - page_w - $clog2(sets);
    endfunction

endpackage

// File: rtl/tlb_set_assoc_if.sv
// Lookup, fill and flush signal bundle for tlb_set_assoc.
// master = core/walker side, slave = TLB side.
interface tlb_set_assoc_if #(
    parameter int unsigned ADDR_W = tlb_pkg::TLB_ADDR_W,
    parameter int unsigned PAGE_W = tlb_pkg::TLB_PAGE_W,
    parameter int unsigned PCID_W = tlb_pkg::TLB_PCID_W
);
    logic                     req_valid;
    logic                     req_ready;
    logic [ADDR_W-1:0]        req_vaddr;
    logic [PCID_W-1:0]        req_pcid;
    logic                     rsp_valid;
    logic                     rsp_hit;
    logic [ADDR_W-1:0]        rsp_paddr;
    logic                     fill_valid;
    logic                     fill_ready;
    logic [ADDR_W-PAGE_W-1:0] fill_vpn;
    logic [PCID_W-1:0]        fill_pcid;
    logic [ADDR_W-PAGE_W-1:0] fill_ppn;
    logic                     flush_valid;
    logic                     flush_all;
    logic [PCID_W-1:0]        flush_pcid;
    logic                     flush_busy;

    modport master (
        output req_valid, req_vaddr, req_pcid,
        output fill_valid, fill_vpn, fill_pcid, fill_ppn,
        output flush_valid, flush_all, flush_pcid,
        input  req_ready, rsp_valid, rsp_hit, rsp_paddr, fill_ready, flush_busy
    );

    modport slave (
        input  req_valid, req_vaddr, req_pcid,
        input  fill_valid, fill_vpn, fill_pcid, fill_ppn,
        input  flush_valid, flush_all, flush_pcid,
        output req_ready, rsp_valid, rsp_hit, rsp_paddr, fill_ready, flush_busy
    );
endinterface

// File: rtl/plru_tree.sv
// Tree pseudo-LRU state for one set: WAYS-1 node bits, combinational victim, MRU update.
// Node bit 0 points the victim walk left, 1 points it right.
module plru_tree #(
    parameter int unsigned WAYS = 8,
    localparam int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_en,
    input  logic [WAY_W-1:0] upd_way,
    output logic [WAY_W-1:0] victim
);
    logic [WAYS-2:0] bits_q;
    logic [WAYS-2:0] bits_d;
    logic [WAY_W:0]  vnode;
    logic [WAY_W:0]  unode;

    // Heap-numbered nodes 1..WAYS-1; leaves WAYS..2*WAYS-1 map to ways.
    always_comb begin
        vnode = (WAY_W+1)'(1);
        for (int unsigned l = 0; l < WAY_W; l++) begin
            vnode = {vnode[WAY_W-1:0], bits_q[WAY_W'(vnode - 1'b1)]};
        end
        victim = vnode[WAY_W-1:0];
    end

    always_comb begin
        bits_d = bits_q;
        unode  = (WAY_W+1)'(1);
        for (int unsigned l = 0; l < WAY_W; l++) begin
            bits_d[WAY_W'(unode - 1'b1)] = ~upd_way[WAY_W-1-l];
            unode = {unode[WAY_W-1:0], upd_way[WAY_W-1-l]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= '0;
        end else if (upd_en) begin
            bits_q <= bits_d;
        end
    end
endmodule

// File: rtl/tlb_set_assoc.sv
// N-way set-associative TLB with PCID-tagged entries, tree-PLRU replacement and set-walking flush.
// Optional TLB_STATS_EN adds saturating hit_cnt / miss_cnt outputs.
module tlb_set_assoc
    import tlb_pkg::*;
#(
    parameter int unsigned ADDR_W = TLB_ADDR_W,
    parameter int unsigned PAGE_W = TLB_PAGE_W,
    parameter int unsigned PCID_W = TLB_PCID_W,
    parameter int unsigned SETS   = 8,
    parameter int unsigned WAYS   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    tlb_set_assoc_if.slave bus
`ifdef TLB_STATS_EN
    ,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt
`endif
);
    localparam int unsigned IDX_W = idx_width(SETS);
    localparam int unsigned TAG_W = tag_width(ADDR_W, PAGE_W, SETS);
    localparam int unsigned VPN_W = ADDR_W - PAGE_W;
    localparam int unsigned WAY_W = $clog2(WAYS);

    tlb_entry_t       mem_q [SETS][WAYS];
    tlb_state_e       state_q, state_d;
    logic [IDX_W-1:0] fl_idx_q;
    logic             fl_all_q;
    logic [PCID_W-1:0] fl_pcid_q;
    logic             flush_start;
    logic             fill_fire;
    logic             req_fire;

    always_comb begin
        state_d        = state_q;
        flush_start    = 1'b0;
        bus.req_ready  = 1'b0;
        bus.fill_ready = 1'b0;
        bus.flush_busy = 1'b0;
        case (state_q)
            IDLE: begin
                bus.fill_ready = !bus.flush_valid;
                bus.req_ready  = !bus.flush_valid && !bus.fill_valid;
                if (bus.flush_valid) begin
                    flush_start = 1'b1;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                bus.flush_busy = 1'b1;
                if (fl_idx_q == IDX_W'(SETS-1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fill_fire = bus.fill_valid && bus.fill_ready;
    assign req_fire  = bus.req_valid && bus.req_ready;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [WAY_W-1:0] lk_way;
    logic [VPN_W-1:0] lk_ppn;

    assign lk_idx = bus.req_vaddr[PAGE_W +: IDX_W];
    assign lk_tag = bus.req_vaddr[ADDR_W-1:PAGE_W+IDX_W];

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        lk_ppn = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (mem_q[lk_idx][w].valid && mem_q[lk_idx][w].tag == TLB_VPN_W'(lk_tag) &&
                mem_q[lk_idx][w].pcid == TLB_PCID_W'(bus.req_pcid)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
                lk_ppn = mem_q[lk_idx][w].ppn[VPN_W-1:0];
            end
        end
    end

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_match, f_inv_found;
    logic [WAY_W-1:0] f_match_way, f_inv_way, f_way;
    logic [WAY_W-1:0] victim [SETS];
    tlb_entry_t       f_entry;

    assign f_idx = bus.fill_vpn[IDX_W-1:0];
    assign f_tag = bus.fill_vpn[VPN_W-1:IDX_W];

    // Replacement choice: same tag+pcid, else lowest invalid way, else PLRU victim.
    always_comb begin
        f_match     = 1'b0;
        f_match_way = '0;
        f_inv_found = 1'b0;
        f_inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (mem_q[f_idx][w].valid && mem_q[f_idx][w].tag == TLB_VPN_W'(f_tag) &&
                mem_q[f_idx][w].pcid == TLB_PCID_W'(bus.fill_pcid)) begin
                f_match     = 1'b1;
                f_match_way = WAY_W'(w);
            end
            if (!mem_q[f_idx][w].valid && !f_inv_found) begin
                f_inv_found = 1'b1;
                f_inv_way   = WAY_W'(w);
            end
        end
        f_way = f_match ? f_match_way : (f_inv_found ? f_inv_way : victim[f_idx]);
        f_entry.valid = 1'b1;
        f_entry.tag   = TLB_VPN_W'(f_tag);
        f_entry.pcid  = TLB_PCID_W'(bus.fill_pcid);
        f_entry.ppn   = TLB_VPN_W'(bus.fill_ppn);
    end

    logic [SETS-1:0]  upd_en;
    logic [WAY_W-1:0] upd_way;

    always_comb begin
        upd_en  = '0;
        upd_way = fill_fire ? f_way : lk_way;
        for (int unsigned s = 0; s < SETS; s++) begin
            upd_en[s] = (req_fire && lk_hit && lk_idx == IDX_W'(s)) ||
                        (fill_fire && f_idx == IDX_W'(s));
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_plru
        plru_tree #(.WAYS(WAYS)) u_plru (
            .clk     (clk),
            .rst_n   (rst_n),
            .upd_en  (upd_en[s]),
            .upd_way (upd_way),
            .victim  (victim[s])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    mem_q[s][w] <= '0;
                end
            end
        end else begin
            if (fill_fire) mem_q[f_idx][f_way] <= f_entry;
            if (state_q == FLUSH) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (fl_all_q || mem_q[fl_idx_q][w].pcid == TLB_PCID_W'(fl_pcid_q))
                        mem_q[fl_idx_q][w].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fl_idx_q      <= '0;
            fl_all_q      <= 1'b0;
            fl_pcid_q     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_paddr <= '0;
        end else begin
            state_q <= state_d;
            if (flush_start) begin
                fl_idx_q  <= '0;
                fl_all_q  <= bus.flush_all;
                fl_pcid_q <= bus.flush_pcid;
            end else if (state_q == FLUSH) begin
                fl_idx_q <= fl_idx_q + 1'b1;
            end
            bus.rsp_valid <= req_fire;
            bus.rsp_hit   <= req_fire && lk_hit;
            bus.rsp_paddr <= (req_fire && lk_hit) ? {lk_ppn, bus.req_vaddr[PAGE_W-1:0]} : '0;
        end
    end

`ifdef TLB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (bus.rsp_valid) begin
            if (bus.rsp_hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tlb_set_assoc.sv
// Self-checking bench for tlb_set_assoc: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a recency-based behavioural model.
module tb_tlb_set_assoc;
    import tlb_pkg::*;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned PAGE_W = 12;
    localparam int unsigned PCID_W = 12;
    localparam int unsigned SETS   = 8;
    localparam int unsigned WAYS   = 8;
    localparam int unsigned VPN_W  = ADDR_W - PAGE_W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tlb_set_assoc_if #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .PCID_W(PCID_W)) bus ();

`ifdef TLB_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    tlb_set_assoc #(
        .ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .PCID_W(PCID_W), .SETS(SETS), .WAYS(WAYS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef TLB_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Behavioural model: replacement follows "at each tree node, go away from the
    // half that holds the most recently used way" using per-way use timestamps.
    bit                m_valid [SETS][WAYS];
    logic [VPN_W-1:0]  m_vpn   [SETS][WAYS];
    logic [VPN_W-1:0]  m_ppn   [SETS][WAYS];
    logic [PCID_W-1:0] m_pcid  [SETS][WAYS];
    longint unsigned   m_use   [SETS][WAYS];
    longint unsigned   m_time;
    int                m_busy;
    bit                m_rsp_valid, m_rsp_hit;
    logic [63:0]       m_rsp_paddr;
    longint unsigned   m_hits, m_misses;
    bit                mon_en = 1'b0;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_use[s][w]   = 0;
            end
        m_time = 0; m_busy = 0;
        m_rsp_valid = 1'b0; m_rsp_hit = 1'b0; m_rsp_paddr = '0;
        m_hits = 0; m_misses = 0;
    endtask

    function automatic longint unsigned max_use(input int s, input int lo, input int n);
        longint unsigned m = 0;
        for (int w = lo; w < lo + n; w++) if (m_use[s][w] > m) m = m_use[s][w];
        return m;
    endfunction

    function automatic int m_victim(input int s);
        int lo = 0;
        int n = WAYS;
        while (n > 1) begin
            int half = n / 2;
            if (max_use(s, lo, half) > max_use(s, lo + half, half)) lo += half;
            n = half;
        end
        return lo;
    endfunction

    task automatic m_fill(input logic [VPN_W-1:0] vpn, input logic [PCID_W-1:0] pc,
                          input logic [VPN_W-1:0] ppn);
        int s = int'(vpn % SETS);
        int way = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_vpn[s][w] == vpn && m_pcid[s][w] == pc) way = w;
        if (way < 0)
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
        if (way < 0) way = m_victim(s);
        m_valid[s][way] = 1'b1; m_vpn[s][way] = vpn; m_pcid[s][way] = pc; m_ppn[s][way] = ppn;
        m_use[s][way] = ++m_time;
    endtask

    task automatic m_lookup(input logic [63:0] va, input logic [PCID_W-1:0] pc);
        logic [VPN_W-1:0] vpn = va[63:PAGE_W];
        int s = int'(vpn % SETS);
        m_rsp_valid = 1'b1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_vpn[s][w] == vpn && m_pcid[s][w] == pc) begin
                m_rsp_hit   = 1'b1;
                m_rsp_paddr = {m_ppn[s][w], va[PAGE_W-1:0]};
                m_use[s][w] = ++m_time;
            end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_rsp_valid) begin
                if (m_rsp_hit) m_hits++; else m_misses++;
            end
            m_rsp_valid = 1'b0; m_rsp_hit = 1'b0; m_rsp_paddr = '0;
            if (m_busy > 0) begin
                m_busy--;
            end else if (bus.flush_valid) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        if (bus.flush_all || m_pcid[s][w] == bus.flush_pcid) m_valid[s][w] = 1'b0;
                m_busy = SETS;
            end else if (bus.fill_valid) begin
                m_fill(bus.fill_vpn, bus.fill_pcid, bus.fill_ppn);
            end else if (bus.req_valid) begin
                m_lookup(bus.req_vaddr, bus.req_pcid);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rsp_valid", bus.rsp_valid, m_rsp_valid);
            chk("rsp_hit", bus.rsp_hit, m_rsp_hit);
            chk("rsp_paddr", bus.rsp_paddr, m_rsp_paddr);
            chk("flush_busy", bus.flush_busy, m_busy > 0);
            chk("fill_ready", bus.fill_ready, m_busy == 0 && !bus.flush_valid);
            chk("req_ready", bus.req_ready, m_busy == 0 && !bus.flush_valid && !bus.fill_valid);
`ifdef TLB_STATS_EN
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_misses);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_lit(input logic [63:0] va, input logic [PCID_W-1:0] pc,
                              input logic eh, input logic [63:0] ep, input string nm);
        int n = 0;
        bus.req_valid = 1'b1; bus.req_vaddr = va; bus.req_pcid = pc;
        #1;
        while (!bus.req_ready && n < 50) begin tick(); n++; end
        if (n >= 50) timeout_fail(nm);
        tick();
        bus.req_valid = 1'b0;
        chk({nm, "_valid"}, bus.rsp_valid, 1'b1);
        chk({nm, "_hit"}, bus.rsp_hit, eh);
        chk({nm, "_paddr"}, bus.rsp_paddr, ep);
    endtask

    task automatic do_fill(input logic [VPN_W-1:0] vpn, input logic [PCID_W-1:0] pc,
                           input logic [VPN_W-1:0] ppn);
        int n = 0;
        bus.fill_valid = 1'b1; bus.fill_vpn = vpn; bus.fill_pcid = pc; bus.fill_ppn = ppn;
        #1;
        while (!bus.fill_ready && n < 50) begin tick(); n++; end
        if (n >= 50) timeout_fail("fill");
        tick();
        bus.fill_valid = 1'b0;
    endtask

    initial begin
        int fcnt;
        int rdy_hi;
        logic [VPN_W-1:0] vpn;
        bus.req_valid = 1'b0; bus.req_vaddr = '0; bus.req_pcid = '0;
        bus.fill_valid = 1'b0; bus.fill_vpn = '0; bus.fill_pcid = '0; bus.fill_ppn = '0;
        bus.flush_valid = 1'b0; bus.flush_all = 1'b0; bus.flush_pcid = '0;

        #2 rst_n = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_flush_busy", bus.flush_busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        lookup_lit(64'h1234_5678, 12'd3, 1'b0, 64'h0, "cold_miss");
        do_fill(52'h12345, 12'd3, 52'hABC);
        lookup_lit(64'h1234_5678, 12'd3, 1'b1, 64'hABC678, "fill_hit");
        lookup_lit(64'h1234_5678, 12'd4, 1'b0, 64'h0, "pcid_miss");

        // Nine tags into set 0; the ninth evicts way 0 (first tag).
        for (int k = 1; k <= 9; k++) do_fill(52'((64 + k) * 8), 12'd1, 52'(256 + k));
        lookup_lit({52'(65 * 8), 12'h010}, 12'd1, 1'b0, 64'h0, "evicted_tag1");
        for (int k = 2; k <= 9; k++)
            lookup_lit({52'((64 + k) * 8), 12'h010}, 12'd1, 1'b1, {52'(256 + k), 12'h010}, "kept_tag");

        do_fill(52'h777, 12'd3, 52'h111);
        do_fill(52'h778, 12'd5, 52'h222);
        bus.flush_valid = 1'b1; bus.flush_all = 1'b0; bus.flush_pcid = 12'd3;
        bus.req_valid = 1'b1; bus.req_vaddr = {52'h778, 12'h0}; bus.req_pcid = 12'd5;
        tick();
        bus.flush_valid = 1'b0;
        fcnt = 0; rdy_hi = 0;
        while (bus.flush_busy && fcnt < 40) begin
            fcnt++;
            if (bus.req_ready) rdy_hi++;
            tick();
        end
        bus.req_valid = 1'b0;
        chk("flush_cycles", 64'(fcnt), 64'd8);
        chk("req_ready_in_flush", 64'(rdy_hi), 64'd0);
        tick();
        lookup_lit({52'h777, 12'h004}, 12'd3, 1'b0, 64'h0, "flushed_pcid3");
        lookup_lit({52'h778, 12'h004}, 12'd5, 1'b1, {52'h222, 12'h004}, "kept_pcid5");
        lookup_lit(64'h1234_5678, 12'd3, 1'b0, 64'h0, "flushed_first");

        bus.fill_valid = 1'b1; bus.fill_vpn = 52'h9A; bus.fill_pcid = 12'd6; bus.fill_ppn = 52'h5555;
        bus.req_valid = 1'b1; bus.req_vaddr = {52'h9A, 12'h321}; bus.req_pcid = 12'd6;
        #1;
        chk("same_cycle_fill_ready", bus.fill_ready, 1'b1);
        chk("same_cycle_req_ready", bus.req_ready, 1'b0);
        tick();
        bus.fill_valid = 1'b0;
        #1;
        chk("req_next_ready", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        chk("req_after_fill_hit", bus.rsp_hit, 1'b1);
        chk("req_after_fill_paddr", bus.rsp_paddr, {52'h5555, 12'h321});

        do_fill(52'h4444, 12'd7, 52'h6666);
        bus.flush_valid = 1'b1; bus.flush_all = 1'b0; bus.flush_pcid = 12'd9;
        tick();
        bus.flush_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_flush_busy", bus.flush_busy, 1'b0);
        chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
        chk("abort_rsp_hit", bus.rsp_hit, 1'b0);
        chk("abort_rsp_paddr", bus.rsp_paddr, 64'h0);
        tick();
        rst_n = 1'b1;
        lookup_lit({52'h4444, 12'h0}, 12'd7, 1'b0, 64'h0, "after_abort_d");
        lookup_lit({52'(69 * 8), 12'h010}, 12'd1, 1'b0, 64'h0, "after_abort_set0");

`ifdef TLB_STATS_EN
        do_fill(52'h31, 12'd2, 52'h77);
        for (int k = 0; k < 3; k++) lookup_lit({52'h31, 12'h0}, 12'd2, 1'b1, {52'h77, 12'h0}, "stat_hit");
        tick();
        chk("stats_hit_cnt", hit_cnt, 32'd3);
        chk("stats_miss_cnt", miss_cnt, 32'd2);
`endif

        for (int c = 0; c < 3000; c++) begin
            vpn = 52'(($urandom_range(0, 5) << 3) | $urandom_range(0, 7));
            bus.req_valid  = ($urandom_range(0, 99) < 60);
            bus.req_vaddr  = {vpn, 12'($urandom)};
            bus.req_pcid   = 12'($urandom_range(3, 5));
            bus.fill_valid = ($urandom_range(0, 99) < 20);
            bus.fill_vpn   = 52'(($urandom_range(0, 5) << 3) | $urandom_range(0, 7));
            bus.fill_pcid  = 12'($urandom_range(3, 5));
            bus.fill_ppn   = 52'($urandom);
            bus.flush_valid = ($urandom_range(0, 199) == 0);
            bus.flush_all   = $urandom_range(0, 1) == 1;
            bus.flush_pcid  = 12'($urandom_range(3, 5));
            tick();
        end
        bus.req_valid = 1'b0; bus.fill_valid = 1'b0; bus.flush_valid = 1'b0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
